// File: rtl/fetch_pkg.sv
// Shared opcode constants, the bubble NOP word, the fetch FSM state type and
// the load-use hazard test used by fetch_controller.
package fetch_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'd9;
  localparam logic [5:0] OP_LW     = 6'd10;
  localparam logic [5:0] OP_SW     = 6'd11;
  localparam logic [5:0] FUNCT_NOP = 6'd1;

  localparam logic [31:0] NOP_WORD = {OP_RTYPE, 5'd0, 5'd0, 5'd0, 5'd9, FUNCT_NOP};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  // True when 'next' is an R-type reading the register that the LW 'prev' writes.
  function automatic logic load_use_hazard(input logic [31:0] prev, input logic [31:0] next);
    logic [4:0] lw_rt;
    lw_rt = prev[20:16];
    return (prev[31:26] == OP_LW) && (lw_rt != 5'd0) &&
           (next[31:26] == OP_RTYPE) &&
           ((next[25:21] == lw_rt) || (next[20:16] == lw_rt));
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory and decode-side handshake bundle of the fetch stage.
interface fetch_if #(
  parameter int ADDR_W = 10
) ();

  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_pc;

  modport master (
    output mem_addr,
    input  mem_rdata,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc
  );

  modport slave (
    input  mem_addr,
    output mem_rdata,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc
  );

endinterface

// File: rtl/fetch_skid_buf.sv
// Output register with a one-entry skid buffer behind it; flush empties both.
// The producer guarantees it never lands data while the skid entry is occupied.
module fetch_skid_buf #(
  parameter int W = 42
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         skid_valid
);

  logic         out_v_q, out_v_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic         skid_v_q, skid_v_d;
  logic [W-1:0] skid_data_q, skid_data_d;

  always_comb begin
    out_v_d     = out_v_q;
    out_data_d  = out_data_q;
    skid_v_d    = skid_v_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      out_v_d  = 1'b0;
      skid_v_d = 1'b0;
    end else if (!out_v_q || out_ready) begin
      // Output register is free this cycle: the older skid entry goes first.
      if (skid_v_q) begin
        out_v_d    = 1'b1;
        out_data_d = skid_data_q;
        skid_v_d   = in_valid;
        if (in_valid) begin
          skid_data_d = in_data;
        end
      end else if (in_valid) begin
        out_v_d    = 1'b1;
        out_data_d = in_data;
      end else begin
        out_v_d = 1'b0;
      end
    end else if (in_valid) begin
      skid_v_d    = 1'b1;
      skid_data_d = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_v_q     <= 1'b0;
      out_data_q  <= '0;
      skid_v_q    <= 1'b0;
      skid_data_q <= '0;
    end else begin
      out_v_q     <= out_v_d;
      out_data_q  <= out_data_d;
      skid_v_q    <= skid_v_d;
      skid_data_q <= skid_data_d;
    end
  end

  assign out_valid  = out_v_q;
  assign out_data   = out_data_q;
  assign skid_valid = skid_v_q;

endmodule

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: PC/issue FSM, 1-cycle read tracking, skid-buffered
// delivery to decode. FETCH_LOAD_USE_STALL_EN adds a NOP bubble after LW hazards.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int START_PC = 0,
  parameter int END_PC   = 23
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  fetch_if.master           bus,
  output logic              busy,
  output logic              halted
);

  localparam int DW = 32 + ADDR_W;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  logic              pend_q, pend_d;
  logic              flush;
  logic              adv;

  logic              buf_valid;
  logic              buf_ready;
  logic [DW-1:0]     buf_data;
  logic              skid_v;
  logic [DW-1:0]     land_data;
  logic [31:0]       buf_instr;
  logic [ADDR_W-1:0] buf_pc;
  logic [31:0]       out_instr;

  // Issue only when the landing read has somewhere to go next cycle.
  assign adv = (state_q == RUN) && !skid_v && !(pend_q && buf_valid && !buf_ready);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_d    = 1'b0;
    pend_pc_d = pend_pc_q;
    flush     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          pc_d    = ADDR_W'(START_PC);
        end
      end
      RUN: begin
        if (adv) begin
          pend_d    = 1'b1;
          pend_pc_d = pc_q;
          pc_d      = pc_q + 1'b1;
          if (pc_q == ADDR_W'(END_PC)) begin
            state_d = HALT;
          end
        end
      end
      HALT: begin
      end
      default: state_d = IDLE;
    endcase
    // Redirect squashes the in-flight read and everything buffered.
    if (redirect_valid && (state_q != IDLE)) begin
      state_d = RUN;
      pc_d    = redirect_pc;
      pend_d  = 1'b0;
      flush   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= ADDR_W'(START_PC);
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  assign land_data = {bus.mem_rdata, pend_pc_q};

  fetch_skid_buf #(
    .W(DW)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (pend_q),
    .in_data   (land_data),
    .out_valid (buf_valid),
    .out_ready (buf_ready),
    .out_data  (buf_data),
    .skid_valid(skid_v)
  );

  assign {buf_instr, buf_pc} = buf_data;

`ifdef FETCH_LOAD_USE_STALL_EN
  logic        bubble;
  logic        last_v_q;
  logic [31:0] last_instr_q;

  // The NOP carries the dependent pc; the real word stays held until after it.
  assign bubble    = buf_valid && last_v_q && load_use_hazard(last_instr_q, buf_instr);
  assign buf_ready = bus.out_ready && !bubble;
  assign out_instr = bubble ? NOP_WORD : buf_instr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_v_q     <= 1'b0;
      last_instr_q <= '0;
    end else if (flush) begin
      last_v_q <= 1'b0;
    end else if (buf_valid && bus.out_ready) begin
      last_v_q     <= 1'b1;
      last_instr_q <= out_instr;
    end
  end
`else
  assign buf_ready = bus.out_ready;
  assign out_instr = buf_instr;
`endif

  assign bus.mem_addr  = pc_q;
  assign bus.out_valid = buf_valid;
  assign bus.out_instr = out_instr;
  assign bus.out_pc    = buf_pc;

  assign busy   = (state_q == RUN) || pend_q || buf_valid || skid_v;
  assign halted = (state_q == HALT) && !pend_q && !buf_valid && !skid_v;

endmodule
